// File: rtl/spmv_mem_pkg.sv
// Shared types for the SpMV memory responder: bus widths and request/response records.
package spmv_mem_pkg;

  localparam int unsigned ADDR_W = 48;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned TAG_W  = 3;

  typedef struct packed {
    logic              is_st;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d_or_tag;
  } req_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  localparam int unsigned REQ_W = $bits(req_t);
  localparam int unsigned RSP_W = $bits(rsp_t);

endpackage

// File: rtl/std_fifo.sv
// Synchronous show-ahead FIFO: head word readable combinationally, push ignored when full.
module std_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               din,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data_c,
  output logic                           empty_c,
  output logic                           full_c,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_c   = (count == '0);
  assign full_c    = (count == CNT_W'(DEPTH));
  assign do_push   = push && !full_c;
  assign do_pop    = pop && !empty_c;
  assign rd_data_c = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/spmv_mem_responder.sv
// In-order load/store memory responder for the SpMV engine.
// Optional statistics counters are enabled with SPMV_MEM_RESPONDER_STATS_EN.
module spmv_mem_responder
  import spmv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2   = 10,
  parameter int unsigned QDEPTH       = 16,
  parameter int unsigned STALL_MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_mem_ld,
  input  logic              req_mem_st,
  input  logic [ADDR_W-1:0] req_mem_addr,
  input  logic [DATA_W-1:0] req_mem_d_or_tag,
  output logic              req_mem_stall,
  output logic              rsp_mem_push,
  output logic [TAG_W-1:0]  rsp_mem_tag,
  output logic [DATA_W-1:0] rsp_mem_q,
  input  logic              rsp_mem_stall,
  output logic              proto_err
`ifdef SPMV_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]       ld_count,
  output logic [31:0]       st_count,
  output logic [31:0]       rsp_stall_cycles
`endif
);

  localparam int unsigned WORDS   = 1 << DEPTH_LOG2;
  localparam int unsigned QCNT_W  = $clog2(QDEPTH + 1);
  localparam int unsigned QCNT_W1 = QCNT_W + 1;

  logic              ready_q;
  logic              in_vld_q;
  logic              in_both_q;
  req_t              in_q;

  req_t              req_head;
  logic              req_empty_c, req_full_c;
  logic [QCNT_W-1:0] req_count;
  logic              req_push_c, req_pop_c;

  logic [DATA_W-1:0] store_mem [WORDS];
  logic [DATA_W-1:0] ram_q;
  logic              ld_vld_q;
  logic [TAG_W-1:0]  ld_tag_q;
  logic [DEPTH_LOG2-1:0] widx_c;

  rsp_t              rsp_head, rsp_din;
  logic              rsp_empty_c, rsp_full_c;
  logic [QCNT_W-1:0] rsp_count;
  logic              rsp_push_c, rsp_pop_c;
  logic              rsp_stall_q;
  logic              rsp_room_c;
  logic              unused_c;

  // Input stage; the first cycle after reset release is ignored via ready_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ready_q   <= 1'b0;
      in_vld_q  <= 1'b0;
      in_both_q <= 1'b0;
      in_q      <= '0;
    end else begin
      ready_q        <= 1'b1;
      in_vld_q       <= ready_q && (req_mem_ld || req_mem_st);
      in_both_q      <= ready_q && req_mem_ld && req_mem_st;
      in_q.is_st     <= req_mem_st;
      in_q.addr      <= req_mem_addr;
      in_q.d_or_tag  <= req_mem_d_or_tag;
    end
  end

  assign req_push_c = rst && in_vld_q;

  std_fifo #(.WIDTH(REQ_W), .DEPTH(QDEPTH)) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_push_c),
    .din       (in_q),
    .pop       (req_pop_c),
    .rd_data_c (req_head),
    .empty_c   (req_empty_c),
    .full_c    (req_full_c),
    .count     (req_count)
  );

  // A load may leave only if its response is guaranteed a slot.
  assign rsp_room_c = (QCNT_W1'(rsp_count) + QCNT_W1'(ld_vld_q)) < QCNT_W1'(QDEPTH);
  assign req_pop_c  = rst && !req_empty_c && (req_head.is_st || rsp_room_c);
  assign widx_c     = req_head.addr[DEPTH_LOG2+2:3];

  // Backing store: single port, synchronous read, never reset.
  always_ff @(posedge clk) begin
    if (req_pop_c) begin
      if (req_head.is_st) store_mem[widx_c] <= req_head.d_or_tag;
      else                ram_q <= store_mem[widx_c];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_vld_q <= 1'b0;
      ld_tag_q <= '0;
    end else begin
      ld_vld_q <= req_pop_c && !req_head.is_st;
      ld_tag_q <= req_head.d_or_tag[TAG_W-1:0];
    end
  end

  assign rsp_push_c   = rst && ld_vld_q;
  assign rsp_din.tag  = ld_tag_q;
  assign rsp_din.data = ram_q;

  std_fifo #(.WIDTH(RSP_W), .DEPTH(QDEPTH)) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push_c),
    .din       (rsp_din),
    .pop       (rsp_pop_c),
    .rd_data_c (rsp_head),
    .empty_c   (rsp_empty_c),
    .full_c    (rsp_full_c),
    .count     (rsp_count)
  );

  assign rsp_pop_c = rst && !rsp_stall_q && !rsp_empty_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_stall_q   <= 1'b0;
      rsp_mem_push  <= 1'b0;
      rsp_mem_tag   <= '0;
      rsp_mem_q     <= '0;
      req_mem_stall <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      rsp_stall_q   <= rsp_mem_stall;
      rsp_mem_push  <= rsp_pop_c;
      if (rsp_pop_c) begin
        rsp_mem_tag <= rsp_head.tag;
        rsp_mem_q   <= rsp_head.data;
      end
      req_mem_stall <= req_count >= QCNT_W'(QDEPTH - STALL_MARGIN);
      proto_err     <= proto_err || in_both_q || (in_vld_q && req_full_c);
    end
  end

`ifdef SPMV_MEM_RESPONDER_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      ld_count         <= '0;
      st_count         <= '0;
      rsp_stall_cycles <= '0;
    end else begin
      if (req_push_c && !req_full_c && !in_q.is_st) ld_count <= ld_count + 32'd1;
      if (req_push_c && !req_full_c && in_q.is_st)  st_count <= st_count + 32'd1;
      if (rsp_mem_stall && !rsp_empty_c) rsp_stall_cycles <= rsp_stall_cycles + 32'd1;
    end
  end
`endif

  assign unused_c = ^{req_head.addr[ADDR_W-1:DEPTH_LOG2+3], req_head.addr[2:0],
                      rsp_full_c};

endmodule
